// File: rtl/data_memory_ctrl_if.sv
// Request/done bus between the MEM stage and the data memory controller.
// master = pipeline side, slave = memory controller side.
interface data_memory_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output we,
        output size,
        output sign_ext,
        output addr,
        output wdata,
        input  busy,
        input  done,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  size,
        input  sign_ext,
        input  addr,
        input  wdata,
        output busy,
        output done,
        output rdata,
        output err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressable data memory with byte/half/word access and error detection.
// Latency: done pulses LATENCY edges after the accept edge; req is dropped while busy.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_ctrl_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    generate
        if (DATA_WIDTH != 32 || LATENCY < 1 || LATENCY > 8) begin : g_cfg_err
            $error("data_memory_ctrl: DATA_WIDTH must be 32 and LATENCY in 1..8");
        end
    endgenerate

    logic [7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        err_pend_q, err_pend_d;
    logic [31:0] ld_q, ld_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]  b0, b1, b2, b3;
    logic        misalign, out_of_range, reserved, acc_err;
    logic        accept, wr_en;
    logic [15:0] ext16;
    logic [23:0] ext24;
    logic [31:0] ld_val;

    // Access decode: everything is evaluated from the live bus at the accept edge.
    always_comb begin
        idx0 = bus.addr[ADDR_WIDTH-1:0];
        idx1 = idx0 + ADDR_WIDTH'(1);
        idx2 = idx0 + ADDR_WIDTH'(2);
        idx3 = idx0 + ADDR_WIDTH'(3);
        b0   = mem[idx0];
        b1   = mem[idx1];
        b2   = mem[idx2];
        b3   = mem[idx3];

        misalign     = ((bus.size == 2'b01) && bus.addr[0]) ||
                       ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
        out_of_range = (bus.addr >> ADDR_WIDTH) != 32'd0;
        reserved     = (bus.size == 2'b11);
        acc_err      = misalign || out_of_range || reserved;

        accept = (state_q == IDLE) && bus.req;
        wr_en  = accept && bus.we && !acc_err;

        ext16 = (bus.sign_ext && b0[7]) ? 16'hFFFF : 16'h0000;
        ext24 = (bus.sign_ext && b0[7]) ? 24'hFFFFFF : 24'h000000;

        case (bus.size)
            2'b00:   ld_val = {ext24, b0};
            2'b01:   ld_val = {ext16, b0, b1};
            default: ld_val = {b0, b1, b2, b3};
        endcase
    end

    // Stores commit at the accept edge, so a reset during the access cannot undo them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (bus.size)
                2'b00: begin
                    mem[idx0] <= bus.wdata[7:0];
                end
                2'b01: begin
                    mem[idx0] <= bus.wdata[15:8];
                    mem[idx1] <= bus.wdata[7:0];
                end
                default: begin
                    mem[idx0] <= bus.wdata[31:24];
                    mem[idx1] <= bus.wdata[23:16];
                    mem[idx2] <= bus.wdata[15:8];
                    mem[idx3] <= bus.wdata[7:0];
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            we_q       <= 1'b0;
            err_pend_q <= 1'b0;
            ld_q       <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            err_pend_q <= err_pend_d;
            ld_q       <= ld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next state: BUSY is left on the edge after the done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter, captured access and result registers.
    always_comb begin
        cnt_d      = cnt_q;
        we_d       = we_q;
        err_pend_d = err_pend_q;
        ld_d       = ld_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;

        if (accept) begin
            cnt_d      = 3'(LATENCY - 1);
            we_d       = bus.we;
            err_pend_d = acc_err;
            ld_d       = ld_val;
        end

        if ((state_q == BUSY) && !done_q) begin
            if (cnt_q == 3'd0) begin
                done_d = 1'b1;
                err_d  = err_pend_q;
                if (!we_q && !err_pend_q) begin
                    rdata_d = ld_q;
                end
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    // Outputs.
    always_comb begin
        bus.busy  = (state_q == BUSY);
        bus.done  = done_q;
        bus.err   = err_q;
        bus.rdata = rdata_q;
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at LATENCY=1, one at LATENCY=4.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req1 = 1'b0;
    logic        req4 = 1'b0;
    logic        t_we = 1'b0;
    logic [1:0]  t_size = 2'b00;
    logic        t_sext = 1'b0;
    logic [31:0] t_addr = 32'd0;
    logic [31:0] t_wdata = 32'd0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          done_seen;

    always #5 clk = ~clk;

    data_memory_ctrl_if b1 ();
    data_memory_ctrl_if b4 ();

    assign b1.req      = req1;
    assign b1.we       = t_we;
    assign b1.size     = t_size;
    assign b1.sign_ext = t_sext;
    assign b1.addr     = t_addr;
    assign b1.wdata    = t_wdata;
    assign b4.req      = req4;
    assign b4.we       = t_we;
    assign b4.size     = t_size;
    assign b4.sign_ext = t_sext;
    assign b4.addr     = t_addr;
    assign b4.wdata    = t_wdata;

    data_memory_ctrl #(.ADDR_WIDTH(10), .LATENCY(1), .DATA_WIDTH(32)) u_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    data_memory_ctrl #(.ADDR_WIDTH(10), .LATENCY(4), .DATA_WIDTH(32)) u_l4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: drive at negedge, accept on next posedge, wait for done, then one more edge.
    task automatic acc(input bit l4, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e, output int n);
        bit found;
        @(negedge clk);
        t_we = w; t_size = sz; t_sext = sx; t_addr = a; t_wdata = d;
        if (l4) req4 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req4 = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            n++;
            if ((l4 ? b4.done : b1.done) === 1'b1) found = 1'b1;
        end
        r = l4 ? b4.rdata : b1.rdata;
        e = l4 ? b4.err : b1.err;
        chk("done_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, b1.busy}, 32'd0);
        chk("rst_done", {31'd0, b1.done}, 32'd0);
        chk("rst_rdata", b1.rdata, 32'd0);
        chk("rst_err", {31'd0, b1.err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load, LATENCY=1
        acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, rd, er, lat);
        chk("st_w_lat", 32'(lat), 32'd1);
        chk("st_w_err", {31'd0, er}, 32'd0);
        chk("st_w_rdata", rd, 32'd0);
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("ld_w_lat", 32'(lat), 32'd1);
        chk("ld_w", rd, 32'h8899AABB);
        chk("ld_w_err", {31'd0, er}, 32'd0);

        // Extension of half and byte loads
        acc(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat);
        chk("ld_h_sx", rd, 32'hFFFF8899);
        acc(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("ld_h_zx", rd, 32'h00008899);
        acc(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
        chk("ld_b_sx", rd, 32'hFFFFFFBB);
        acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat);
        chk("ld_b_zx", rd, 32'h00000099);

        // Partial stores
        acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, rd, er, lat);
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("st_b_word", rd, 32'h8855AABB);
        acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, rd, er, lat);
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("st_h_word", rd, 32'h88551234);

        // Error cases: rdata must keep 0x88551234, memory untouched
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lat);
        chk("mis_ld_w_err", {31'd0, er}, 32'd1);
        chk("mis_ld_w_lat", 32'(lat), 32'd1);
        chk("mis_ld_w_rd", rd, 32'h88551234);
        acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, rd, er, lat);
        chk("mis_st_h_err", {31'd0, er}, 32'd1);
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat);
        chk("oor_ld_err", {31'd0, er}, 32'd1);
        chk("oor_ld_rd", rd, 32'h88551234);
        acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h01020304, rd, er, lat);
        chk("oor_st_err", {31'd0, er}, 32'd1);
        acc(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, rd, er, lat);
        chk("rsv_st_err", {31'd0, er}, 32'd1);
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("mem_intact", rd, 32'h88551234);
        chk("mem_intact_err", {31'd0, er}, 32'd0);

        // Top-of-memory word is legal
        acc(1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hDEADBEEF, rd, er, lat);
        chk("top_st_err", {31'd0, er}, 32'd0);
        acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
        chk("top_ld_w", rd, 32'hDEADBEEF);
        acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, rd, er, lat);
        chk("top_ld_b", rd, 32'h000000EF);

        // LATENCY=4: req held for 3 edges, only the first is accepted
        @(negedge clk);
        t_we = 1'b1; t_size = 2'b10; t_sext = 1'b0; t_addr = 32'h20; t_wdata = 32'hCAFEF00D;
        req4 = 1'b1;
        @(posedge clk);
        #1;
        t_wdata = 32'h11111111;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 2) req4 = 1'b0;
            chk($sformatf("l4_busy_%0d", k), {31'd0, b4.busy}, (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("l4_done_%0d", k), {31'd0, b4.done}, (k == 4) ? 32'd1 : 32'd0);
        end
        acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("l4_ld_lat", 32'(lat), 32'd4);
        chk("l4_ld", rd, 32'hCAFEF00D);

        // Reset two cycles into a LATENCY=4 store
        @(negedge clk);
        t_we = 1'b1; t_size = 2'b10; t_addr = 32'h40; t_wdata = 32'h0BADCAFE;
        req4 = 1'b1;
        @(posedge clk);
        #1;
        req4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("l4_pre_rst_busy", {31'd0, b4.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("l4_rst_busy", {31'd0, b4.busy}, 32'd0);
        chk("l4_rst_done", {31'd0, b4.done}, 32'd0);
        chk("l4_rst_err", {31'd0, b4.err}, 32'd0);
        chk("l4_rst_rdata", b4.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (b4.done !== 1'b0) done_seen++;
        end
        chk("l4_no_done", 32'(done_seen), 32'd0);
        acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("l4_post_rst_ld", rd, 32'h0BADCAFE);
        chk("l4_post_rst_err", {31'd0, er}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
